// File: rtl/avmem_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM memory model.
// The optional random-wait feature is enabled with the macro AVMEM_LFSR_WAIT_EN.
package avmem_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } avmem_state_e;

    // Bytes per memory word
    localparam int WORD_BYTES = 4;

    // Fibonacci feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/avmem_lfsr16.sv
// 16-bit Fibonacci LFSR used to randomise the per-transfer stall length.
// Only instantiated when AVMEM_LFSR_WAIT_EN is defined.
module avmem_lfsr16
    import avmem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] value
);

    logic [15:0] lfsr_r;
    logic        feedback_s;

    assign feedback_s = ^(lfsr_r & LFSR_TAP_MASK);
    assign value      = lfsr_r;

    // Shift register: reseed on reset, advance once per step request
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_r <= SEED;
        end else if (step) begin
            lfsr_r <= {lfsr_r[14:0], feedback_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

endmodule

// File: rtl/avalon_waitstate_mem.sv
// Avalon-MM responder RAM with programmable waitrequest stalls and a preload port.
// Every transfer is held off for a number of cycles before it completes so that
// a master's waitrequest handling is exercised. Define AVMEM_LFSR_WAIT_EN to draw
// the stall length per transfer from an LFSR (1..WAIT_CYCLES) instead of a fixed
// WAIT_CYCLES.
module avalon_waitstate_mem
    import avmem_pkg::*;
#(
    parameter int          DEPTH_W     = 10,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          address,
    input  logic                 write,
    input  logic                 read,
    output logic                 waitrequest,
    input  logic [31:0]          writedata,
    input  logic [3:0]           byteenable,
    output logic [31:0]          readdata,
    input  logic                 load_en,
    input  logic [DEPTH_W+7:0]   load_addr,
    input  logic [31:0]          load_data
);

    localparam int          DEPTH      = 1 << DEPTH_W;
    localparam logic [31:0] SPAN_BYTES = 32'(WORD_BYTES) << DEPTH_W;
    localparam logic [3:0]  WAIT_MAX   = 4'(WAIT_CYCLES);

    logic [31:0]          mem_r [DEPTH];

    avmem_state_e         state_r;
    avmem_state_e         state_nxt_s;
    logic [3:0]           cnt_r;
    logic [3:0]           cnt_nxt_s;
    logic [31:0]          readdata_r;

    logic                 req_s;
    logic [31:0]          offset_s;
    logic                 in_range_s;
    logic [DEPTH_W-1:0]   idx_s;
    logic [DEPTH_W-1:0]   load_idx_s;
    logic                 load_in_range_s;
    logic [3:0]           wait_load_s;
    logic                 start_s;
    logic                 enter_done_s;
    logic                 commit_s;
    logic                 unused_ok_s;

    // Address decode relative to the base, wrapping in 32 bits so addresses
    // below the base land far out of range.
    assign req_s           = read | write;
    assign offset_s        = address - BASE_ADDR;
    assign in_range_s      = (offset_s < SPAN_BYTES);
    assign idx_s           = offset_s[DEPTH_W+1:2];
    assign load_idx_s      = load_addr[DEPTH_W+1:2];
    assign load_in_range_s = (load_addr[DEPTH_W+7:DEPTH_W+2] == 6'd0);

    assign start_s         = (state_r == IDLE) && req_s;
    // A write completes on the edge leaving DONE; a reset in that cycle abandons it.
    assign commit_s        = (state_r == DONE) && write && in_range_s && !reset;

    assign waitrequest     = req_s && (state_r != DONE);
    assign readdata        = readdata_r;

`ifdef AVMEM_LFSR_WAIT_EN
    logic [15:0] lfsr_s;

    avmem_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (start_s),
        .value (lfsr_s)
    );

    assign wait_load_s = 4'(lfsr_s[3:0] % WAIT_MAX) + 4'd1;
    assign unused_ok_s = ^{load_addr[1:0], lfsr_s[15:4]};
`else
    assign wait_load_s = WAIT_MAX;
    assign unused_ok_s = ^{load_addr[1:0], LFSR_SEED};
`endif

    // Next-state logic. cnt_r holds the stall cycles still owed including the
    // current one, so the request cycle in IDLE already counts as the first stall
    // and DONE is reached exactly wait_load_s cycles after the request appears.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        enter_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    if (wait_load_s <= 4'd1) begin
                        state_nxt_s  = DONE;
                        cnt_nxt_s    = 4'd0;
                        enter_done_s = 1'b1;
                    end else begin
                        state_nxt_s  = WAIT;
                        cnt_nxt_s    = wait_load_s - 4'd1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!req_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_r <= 4'd1) begin
                    state_nxt_s  = DONE;
                    cnt_nxt_s    = 4'd0;
                    enter_done_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Sequencer state and stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Read data capture on the edge entering DONE; a combined read+write is a write
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'h0000_0000;
        end else if (enter_done_s && read && !write) begin
            readdata_r <= in_range_s ? mem_r[idx_s] : 32'h0000_0000;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    // Storage: bus write commit, then preload so a same-word preload wins
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[idx_s] <= byte_merge(mem_r[idx_s], writedata, byteenable);
        end
        if (load_en && load_in_range_s) begin
            mem_r[load_idx_s] <= load_data;
        end
    end

endmodule
